// File: rtl/user_input_conditioner.sv
// Synchronise, debounce and edge-detect switches/buttons; publish settled changes as snapshots.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES edges raw->level; snapshot held under !snap_ready, stalls collapse to latest value.
module user_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int SYNC_STAGES     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ch_raw,
   input  logic [3:0]  bt_raw_n,
   output logic [7:0]  ch_db,
   output logic [3:0]  bt_db,
   output logic [3:0]  bt_press,
   output logic [11:0] snap_data,
   output logic        snap_valid,
   input  logic        snap_ready
);

   localparam int              nb       = 12;
   localparam logic [nb-1:0]   sync_rst = 12'hF00;
   localparam logic [CNT_W-1:0] cnt_term = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   logic [nb-1:0]    raw;
   logic [nb-1:0]    sync_q [SYNC_STAGES];
   logic [nb-1:0]    s;
   logic [nb-1:0]    stable;
   logic [nb-1:0]    stable_nxt;
   logic [nb-1:0]    diff;
   logic [nb-1:0]    upd;
   logic [CNT_W-1:0] cnt [nb];
   logic             change;
   logic [3:0]       bt_db_prev;

   state_t           state;
   state_t           state_nxt;
   logic             dirty;
   logic             dirty_nxt;
   logic             valid_nxt;
   logic             capture;
   logic             accept;

   assign raw = {bt_raw_n, ch_raw};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_rst;
         end
      end else begin
         sync_q[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // buttons become active-high only after the last synchroniser stage
   assign s = {~sync_q[SYNC_STAGES-1][11:8], sync_q[SYNC_STAGES-1][7:0]};

   always_comb begin
      diff = s ^ stable;
      upd  = '0;
      for (int i = 0; i < nb; i++) begin
         upd[i] = diff[i] && (cnt[i] == cnt_term);
      end
   end

   // upd only fires where s differs from stable, so flipping those bits yields s
   assign stable_nxt = stable ^ upd;
   assign change     = |upd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < nb; i++) begin
            cnt[i] <= '0;
         end
         stable <= '0;
      end else begin
         for (int i = 0; i < nb; i++) begin
            if (!diff[i] || upd[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         stable <= stable_nxt;
      end
   end

   assign ch_db = stable[7:0];
   assign bt_db = stable[11:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bt_db_prev <= '0;
         bt_press   <= '0;
      end else begin
         bt_db_prev <= bt_db;
         bt_press   <= bt_db & ~bt_db_prev;
      end
   end

   assign accept = snap_valid && snap_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (change) state_nxt = HOLD;
         HOLD: if (accept && !dirty && !change) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // a change seen while stalled is remembered so the final value is always delivered
   always_comb begin
      capture   = 1'b0;
      valid_nxt = snap_valid;
      dirty_nxt = dirty;
      case (state)
         IDLE: begin
            if (change) begin
               capture   = 1'b1;
               valid_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (accept) begin
               if (dirty || change) begin
                  capture   = 1'b1;
                  dirty_nxt = 1'b0;
               end else begin
                  valid_nxt = 1'b0;
               end
            end else if (change) begin
               dirty_nxt = 1'b1;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            dirty_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_valid <= 1'b0;
         dirty      <= 1'b0;
         snap_data  <= '0;
      end else begin
         snap_valid <= valid_nxt;
         dirty      <= dirty_nxt;
         if (capture) begin
            snap_data <= stable_nxt;
         end
      end
   end

endmodule
